// File: rtl/f_fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM encoding, fixed PC constants,
// redirect-source priority encoding and the fetch-address legality test.
package f_fetch_seq_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] PC_MIN_DEF   = 32'h0000_3000;
    localparam logic [31:0] PC_MAX_DEF   = 32'h0000_6ffc;
    localparam int          STALL_MAX_DEF = 16;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } fetch_state_e;

    // Ordered lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } redirect_src_e;

    function automatic logic pc_legal(input logic [31:0] pc,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
    endfunction

endpackage

// File: rtl/f_redirect_sel.sv
// Prioritised next-PC selection with fetch-address legality check; an illegal
// target is replaced by the exception vector and reported as a fault.
module f_redirect_sel
    import f_fetch_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
    parameter logic [31:0] PC_MIN  = PC_MIN_DEF,
    parameter logic [31:0] PC_MAX  = PC_MAX_DEF
) (
    input  logic [31:0] pc_in,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    output logic [31:0] sel_pc,
    output logic        any_req,
    output logic        fault
);

    redirect_src_e src;
    logic [31:0]   raw_pc;

    always_comb begin
        src = SRC_SEQ;
        if (exc_req)       src = SRC_EXC;
        else if (eret_req) src = SRC_ERET;
        else if (jr_req)   src = SRC_JR;
        else if (j_req)    src = SRC_J;
        else if (br_req)   src = SRC_BR;
    end

    always_comb begin
        raw_pc = pc_in + 32'd4;
        case (src)
            SRC_EXC:  raw_pc = EXC_VEC;
            SRC_ERET: raw_pc = epc;
            SRC_JR:   raw_pc = jr_target;
            SRC_J:    raw_pc = j_target;
            SRC_BR:   raw_pc = br_target;
            default:  raw_pc = pc_in + 32'd4;
        endcase
    end

    // The exception vector is trusted even if it were parameterised out of range.
    assign fault   = (src != SRC_EXC) && !pc_legal(raw_pc, PC_MIN, PC_MAX);
    assign sel_pc  = fault ? EXC_VEC : raw_pc;
    assign any_req = exc_req | eret_req | jr_req | j_req | br_req;

endmodule

// File: rtl/f_fetch_seq.sv
// Fetch-stage sequencer: drives IFU npc/pcwe, parks a redirect that arrives
// during a stall and replays it on release, and watches for endless stalls.
module f_fetch_seq
    import f_fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter logic [31:0] PC_MIN    = PC_MIN_DEF,
    parameter logic [31:0] PC_MAX    = PC_MAX_DEF,
    parameter int          STALL_MAX = STALL_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        jr_req,
    input  logic [31:0] jr_target,
    input  logic        j_req,
    input  logic [31:0] j_target,
    input  logic        br_req,
    input  logic [31:0] br_target,
    output logic [31:0] npc,
    output logic        pcwe,
    output logic        flush_d,
    output logic        pc_fault,
    output logic        pend_valid,
    output logic        stall_timeout
);

    localparam int             CW      = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(STALL_MAX);

    fetch_state_e  state_reg, state_next;
    logic [31:0]   pend_pc_reg, pend_pc_next;
    logic          pend_fault_reg, pend_fault_next;
    logic          pc_fault_reg, pc_fault_next;
    logic [CW-1:0] stall_cnt_reg, stall_cnt_next;
    logic          stall_timeout_reg, stall_timeout_next;

    logic [31:0]   sel_pc;
    logic          any_req;
    logic          fault;

    f_redirect_sel #(
        .EXC_VEC (EXC_VEC),
        .PC_MIN  (PC_MIN),
        .PC_MAX  (PC_MAX)
    ) u_redirect_sel (
        .pc_in     (pc_in),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc       (epc),
        .jr_req    (jr_req),
        .jr_target (jr_target),
        .j_req     (j_req),
        .j_target  (j_target),
        .br_req    (br_req),
        .br_target (br_target),
        .sel_pc    (sel_pc),
        .any_req   (any_req),
        .fault     (fault)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= ST_BOOT;
            pend_pc_reg       <= 32'd0;
            pend_fault_reg    <= 1'b0;
            pc_fault_reg      <= 1'b0;
            stall_cnt_reg     <= '0;
            stall_timeout_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pend_pc_reg       <= pend_pc_next;
            pend_fault_reg    <= pend_fault_next;
            pc_fault_reg      <= pc_fault_next;
            stall_cnt_reg     <= stall_cnt_next;
            stall_timeout_reg <= stall_timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pend_pc_next    = pend_pc_reg;
        pend_fault_next = pend_fault_reg;
        pc_fault_next   = 1'b0;
        npc             = sel_pc;
        pcwe            = 1'b0;
        flush_d         = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                npc        = RESET_PC;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    pcwe          = 1'b1;
                    flush_d       = exc_req | fault;
                    pc_fault_next = fault;
                end else if (any_req) begin
                    // A faulting target is parked too; its pulse is deferred to replay.
                    pend_pc_next    = sel_pc;
                    pend_fault_next = fault;
                    state_next      = ST_PEND;
                end
            end
            ST_PEND: begin
                npc = pend_pc_reg;
                if (stall) begin
                    if (exc_req) begin
                        pend_pc_next    = EXC_VEC;
                        pend_fault_next = 1'b0;
                    end
                end else begin
                    pcwe            = 1'b1;
                    state_next      = ST_RUN;
                    pend_fault_next = 1'b0;
                    if (exc_req) begin
                        npc     = EXC_VEC;
                        flush_d = 1'b1;
                    end else begin
                        flush_d       = (pend_pc_reg == EXC_VEC);
                        pc_fault_next = pend_fault_reg;
                    end
                end
            end
            default: begin
                npc        = RESET_PC;
                state_next = ST_BOOT;
            end
        endcase
    end

    always_comb begin
        if (!stall)
            stall_cnt_next = '0;
        else if (stall_cnt_reg == CNT_MAX)
            stall_cnt_next = stall_cnt_reg;
        else
            stall_cnt_next = stall_cnt_reg + 1'b1;
        stall_timeout_next = stall_timeout_reg | (stall_cnt_next == CNT_MAX);
    end

    assign pc_fault      = pc_fault_reg;
    assign pend_valid    = (state_reg == ST_PEND);
    assign stall_timeout = stall_timeout_reg;

endmodule

// File: tb/tb_f_fetch_seq.sv
// Scoreboard bench for f_fetch_seq: each cycle's expected outputs are queued as
// the stimulus is applied and compared when the outputs settle.
module tb_f_fetch_seq;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        stall;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic        jr_req;
    logic [31:0] jr_target;
    logic        j_req;
    logic [31:0] j_target;
    logic        br_req;
    logic [31:0] br_target;
    logic [31:0] npc;
    logic        pcwe;
    logic        flush_d;
    logic        pc_fault;
    logic        pend_valid;
    logic        stall_timeout;

    f_fetch_seq dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .stall         (stall),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .jr_req        (jr_req),
        .jr_target     (jr_target),
        .j_req         (j_req),
        .j_target      (j_target),
        .br_req        (br_req),
        .br_target     (br_target),
        .npc           (npc),
        .pcwe          (pcwe),
        .flush_d       (flush_d),
        .pc_fault      (pc_fault),
        .pend_valid    (pend_valid),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          chk_npc;
        logic [31:0] npc;
        logic        pcwe;
        logic        flush;
        logic        fault;
        logic        pv;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] EXC = 32'h0000_4180;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input bit chk_npc, input logic [31:0] e_npc,
                            input logic e_pcwe, input logic e_flush, input logic e_fault,
                            input logic e_pv, input logic e_to);
        exp_t e;
        e.tag = tag; e.chk_npc = chk_npc; e.npc = e_npc; e.pcwe = e_pcwe;
        e.flush = e_flush; e.fault = e_fault; e.pv = e_pv; e.to = e_to;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = exp_q.pop_front();
        $display("txn %-10s npc=%h pcwe=%b flush_d=%b pc_fault=%b pend_valid=%b timeout=%b",
                 e.tag, npc, pcwe, flush_d, pc_fault, pend_valid, stall_timeout);
        if (e.chk_npc) check_val({e.tag, ".npc"}, npc, e.npc);
        check_val({e.tag, ".pcwe"},     32'(pcwe),          32'(e.pcwe));
        check_val({e.tag, ".flush_d"},  32'(flush_d),       32'(e.flush));
        check_val({e.tag, ".pc_fault"}, 32'(pc_fault),      32'(e.fault));
        check_val({e.tag, ".pend"},     32'(pend_valid),    32'(e.pv));
        check_val({e.tag, ".timeout"},  32'(stall_timeout), 32'(e.to));
    endtask

    // One clock cycle: queue expectation, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input bit chk_npc, input logic [31:0] e_npc,
                       input logic e_pcwe, input logic e_flush, input logic e_fault,
                       input logic e_pv, input logic e_to);
        push_exp(tag, chk_npc, e_npc, e_pcwe, e_flush, e_fault, e_pv, e_to);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        exc_req = 1'b0; eret_req = 1'b0; jr_req = 1'b0; j_req = 1'b0; br_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; pc_in = 32'h3000; stall = 1'b0;
        epc = 32'h0; jr_target = 32'h0; j_target = 32'h0; br_target = 32'h0;
        clr_req();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 1, 32'h3000, 0, 0, 0, 0, 0);

        reset = 1'b1;
        cyc("boot", 0, 32'h0, 0, 0, 0, 0, 0);
        cyc("seq", 1, 32'h3004, 1, 0, 0, 0, 0);

        pc_in = 32'h3004; br_req = 1'b1; br_target = 32'h3100;
        cyc("br", 1, 32'h3100, 1, 0, 0, 0, 0);
        exc_req = 1'b1;
        cyc("br_exc", 1, EXC, 1, 1, 0, 0, 0);
        clr_req();

        eret_req = 1'b1; epc = 32'h3500; jr_req = 1'b1; jr_target = 32'h3600;
        cyc("eret_jr", 1, 32'h3500, 1, 0, 0, 0, 0);
        clr_req();
        br_req = 1'b1; br_target = 32'h6ffc;
        cyc("br_max", 1, 32'h6ffc, 1, 0, 0, 0, 0);
        clr_req();

        // Redirect held across a 3-cycle stall, replayed once, then sequential.
        pc_in = 32'h3100; stall = 1'b1; j_req = 1'b1; j_target = 32'h3200;
        cyc("st_j1", 0, 32'h0, 0, 0, 0, 0, 0);
        cyc("st_j2", 0, 32'h0, 0, 0, 0, 1, 0);
        cyc("st_j3", 0, 32'h0, 0, 0, 0, 1, 0);
        stall = 1'b0; clr_req();
        cyc("rel_j", 1, 32'h3200, 1, 0, 0, 1, 0);
        pc_in = 32'h3200;
        cyc("post_j", 1, 32'h3204, 1, 0, 0, 0, 0);

        // Misaligned and out-of-range jr targets fault for exactly one cycle.
        pc_in = 32'h3204; jr_req = 1'b1; jr_target = 32'h3002;
        cyc("jr_mis", 1, EXC, 1, 1, 0, 0, 0);
        clr_req(); pc_in = EXC;
        cyc("jr_mis_p", 1, 32'h4184, 1, 0, 1, 0, 0);
        cyc("jr_mis_q", 1, 32'h4184, 1, 0, 0, 0, 0);
        jr_req = 1'b1; jr_target = 32'h8000;
        cyc("jr_oor", 1, EXC, 1, 1, 0, 0, 0);
        clr_req();
        cyc("jr_oor_p", 1, 32'h4184, 1, 0, 1, 0, 0);
        cyc("jr_oor_q", 1, 32'h4184, 1, 0, 0, 0, 0);

        pc_in = 32'hffff_fffc;
        cyc("wrap", 1, EXC, 1, 1, 0, 0, 0);
        pc_in = 32'h3000;
        cyc("wrap_p", 1, 32'h3004, 1, 0, 1, 0, 0);

        // Exception arriving while a jump is parked replaces it.
        stall = 1'b1; j_req = 1'b1; j_target = 32'h3200;
        cyc("pe_j", 0, 32'h0, 0, 0, 0, 0, 0);
        clr_req(); exc_req = 1'b1;
        cyc("pe_exc", 0, 32'h0, 0, 0, 0, 1, 0);
        clr_req();
        cyc("pe_hold", 0, 32'h0, 0, 0, 0, 1, 0);
        stall = 1'b0;
        cyc("pe_rel", 1, EXC, 1, 1, 0, 1, 0);
        cyc("pe_post", 1, 32'h3004, 1, 0, 0, 0, 0);

        // Fault parked during stall: pulse appears after replay.
        stall = 1'b1; jr_req = 1'b1; jr_target = 32'h8000;
        cyc("pf_st1", 0, 32'h0, 0, 0, 0, 0, 0);
        clr_req();
        cyc("pf_st2", 0, 32'h0, 0, 0, 0, 1, 0);
        stall = 1'b0;
        cyc("pf_rel", 1, EXC, 1, 1, 0, 1, 0);
        cyc("pf_post", 1, 32'h3004, 1, 0, 1, 0, 0);

        // Watchdog: 16 stall cycles set the sticky timeout.
        stall = 1'b1;
        for (int i = 0; i < 16; i++) cyc($sformatf("wd%0d", i), 0, 32'h0, 0, 0, 0, 0, 0);
        cyc("wd_hit", 0, 32'h0, 0, 0, 0, 0, 1);
        stall = 1'b0;
        cyc("wd_stick", 1, 32'h3004, 1, 0, 0, 0, 1);

        // Asynchronous reset while a redirect is parked.
        stall = 1'b1; j_req = 1'b1; j_target = 32'h3200;
        cyc("rp_j", 0, 32'h0, 0, 0, 0, 0, 1);
        cyc("rp_hold", 0, 32'h0, 0, 0, 0, 1, 1);
        reset = 1'b0;
        push_exp("rp_async", 1, 32'h3000, 0, 0, 0, 0, 0);
        #1;
        pop_check();
        @(posedge clk);
        #1;
        reset = 1'b1; stall = 1'b0; clr_req();
        cyc("rp_boot", 0, 32'h0, 0, 0, 0, 0, 0);
        cyc("rp_seq", 1, 32'h3004, 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
